// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between scalar and vector issue
module alu_arbiter #(
   parameter int OP_W   = 5,
   parameter int RD_W   = 7,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OP_W-1:0]   req_opcode,
   input  logic [2*RD_W-1:0]   req_rd,
   input  logic [2*DATA_W-1:0] req_rs,
   input  logic [2*DATA_W-1:0] req_rsi,
   input  logic [2*DATA_W-1:0] req_rt,
   output logic [OP_W-1:0]     alu_opcode,
   output logic [RD_W-1:0]     alu_rd,
   output logic [DATA_W-1:0]   alu_rs,
   output logic [DATA_W-1:0]   alu_rsi,
   output logic [DATA_W-1:0]   alu_rt,
   input  logic [RD_W-1:0]     alu_rd_out,
   input  logic [RD_W-1:0]     alu_branch,
   input  logic [OP_W-1:0]     alu_op_out,
   input  logic [DATA_W-1:0]   alu_result,
   output logic                res_valid,
   input  logic                res_ready,
   output logic                res_id,
   output logic [RD_W-1:0]     res_rd,
   output logic [RD_W-1:0]     res_branch,
   output logic [OP_W-1:0]     res_opcode,
   output logic [DATA_W-1:0]   res_data
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0] state;
   logic [1:0] nextState;
   logic [1:0] grant;
   logic       lastGrant;
   logic       grantId;
   logic       acceptWin;
   logic       accept;
   logic       winner;

   // Round-robin pick and accept window; a pending result must be drained in the same cycle to accept
   always_comb begin
      acceptWin = !rst && ((state == IDLE) || ((state == DONE) && res_ready));
      grant[0]  = req_valid[0] && (!req_valid[1] || lastGrant);
      grant[1]  = req_valid[1] && (!req_valid[0] || !lastGrant);
      req_ready = acceptWin ? grant : 2'b00;
      accept    = |req_ready;
      winner    = grant[1];
   end

   // Next-state: one EXEC cycle for the ALU to settle, DONE holds the result until taken
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = EXEC;
         EXEC:    nextState = DONE;
         DONE:    if (res_ready) nextState = accept ? EXEC : IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Register the winner's operands onto the ALU; they hold until the next accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_opcode <= '0;
         alu_rd     <= '0;
         alu_rs     <= '0;
         alu_rsi    <= '0;
         alu_rt     <= '0;
         lastGrant  <= 1'b1;
         grantId    <= 1'b0;
      end else if (accept) begin
         alu_opcode <= winner ? req_opcode[OP_W +: OP_W]   : req_opcode[0 +: OP_W];
         alu_rd     <= winner ? req_rd[RD_W +: RD_W]       : req_rd[0 +: RD_W];
         alu_rs     <= winner ? req_rs[DATA_W +: DATA_W]   : req_rs[0 +: DATA_W];
         alu_rsi    <= winner ? req_rsi[DATA_W +: DATA_W]  : req_rsi[0 +: DATA_W];
         alu_rt     <= winner ? req_rt[DATA_W +: DATA_W]   : req_rt[0 +: DATA_W];
         lastGrant  <= winner;
         grantId    <= winner;
      end
   end

   // Capture ALU outputs at the end of EXEC; valid clears on handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_valid  <= 1'b0;
         res_id     <= 1'b0;
         res_rd     <= '0;
         res_branch <= '0;
         res_opcode <= '0;
         res_data   <= '0;
      end else if (state == EXEC) begin
         res_valid  <= 1'b1;
         res_id     <= grantId;
         res_rd     <= alu_rd_out;
         res_branch <= alu_branch;
         res_opcode <= alu_op_out;
         res_data   <= alu_result;
      end else if (res_valid && res_ready) begin
         res_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

   localparam int OP_W   = 5;
   localparam int RD_W   = 7;
   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [1:0]          reqValid;
   logic [1:0]          reqReady;
   logic [2*OP_W-1:0]   reqOpcode;
   logic [2*RD_W-1:0]   reqRd;
   logic [2*DATA_W-1:0] reqRs;
   logic [2*DATA_W-1:0] reqRsi;
   logic [2*DATA_W-1:0] reqRt;
   logic [OP_W-1:0]     aluOpcode;
   logic [RD_W-1:0]     aluRd;
   logic [DATA_W-1:0]   aluRs;
   logic [DATA_W-1:0]   aluRsi;
   logic [DATA_W-1:0]   aluRt;
   logic [RD_W-1:0]     aluRdOut;
   logic [RD_W-1:0]     aluBranch;
   logic [OP_W-1:0]     aluOpOut;
   logic [DATA_W-1:0]   aluResult;
   logic                resValid;
   logic                resReady;
   logic                resId;
   logic [RD_W-1:0]     resRd;
   logic [RD_W-1:0]     resBranch;
   logic [OP_W-1:0]     resOpcode;
   logic [DATA_W-1:0]   resData;

   int checkCount = 0;
   int errCount   = 0;

   always #5 clk = ~clk;

   // ALU model: add, pass-through rd/opcode, branch = rd + 1
   assign aluResult = aluRs + aluRt;
   assign aluRdOut  = aluRd;
   assign aluBranch = aluRd + 7'd1;
   assign aluOpOut  = aluOpcode;

   alu_arbiter #(.OP_W(OP_W), .RD_W(RD_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(reqValid), .req_ready(reqReady),
      .req_opcode(reqOpcode), .req_rd(reqRd), .req_rs(reqRs), .req_rsi(reqRsi), .req_rt(reqRt),
      .alu_opcode(aluOpcode), .alu_rd(aluRd), .alu_rs(aluRs), .alu_rsi(aluRsi), .alu_rt(aluRt),
      .alu_rd_out(aluRdOut), .alu_branch(aluBranch), .alu_op_out(aluOpOut), .alu_result(aluResult),
      .res_valid(resValid), .res_ready(resReady), .res_id(resId),
      .res_rd(resRd), .res_branch(resBranch), .res_opcode(resOpcode), .res_data(resData)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester 0: opcode 3, rd 9, rs 5, rsi 0x11, rt 7 -> result 12, branch 10
   // Requester 1: opcode 6, rd 30, rs 200, rsi 0x22, rt 2 -> result 202, branch 31
   initial begin
      rst       = 1'b1;
      reqValid  = 2'b11;
      resReady  = 1'b0;
      reqOpcode = {5'd6, 5'd3};
      reqRd     = {7'd30, 7'd9};
      reqRs     = {32'd200, 32'd5};
      reqRsi    = {32'h22, 32'h11};
      reqRt     = {32'd2, 32'd7};

      tick();
      checkVal("rst_req_ready", reqReady, 2'b00);
      checkVal("rst_res_valid", resValid, 1'b0);
      checkVal("rst_alu_rs", aluRs, 32'd0);
      checkVal("rst_res_data", resData, 32'd0);
      rst = 1'b0;
      #1;
      checkVal("first_grant", reqReady, 2'b01);

      // Single op from requester 0
      reqValid = 2'b01;
      #1;
      checkVal("r0_only_ready", reqReady, 2'b01);
      tick();
      reqValid = 2'b00;
      #1;
      checkVal("exec_req_ready", reqReady, 2'b00);
      checkVal("exec_res_valid", resValid, 1'b0);
      checkVal("alu_opcode", aluOpcode, 5'd3);
      checkVal("alu_rs", aluRs, 32'd5);
      checkVal("alu_rsi", aluRsi, 32'h11);
      checkVal("alu_rt", aluRt, 32'd7);
      checkVal("alu_rd", aluRd, 7'd9);
      tick();
      checkVal("single_res_valid", resValid, 1'b1);
      checkVal("single_res_id", resId, 1'b0);
      checkVal("single_res_data", resData, 32'd12);
      checkVal("single_res_rd", resRd, 7'd9);
      checkVal("single_res_branch", resBranch, 7'd10);
      checkVal("single_res_opcode", resOpcode, 5'd3);
      resReady = 1'b1;
      tick();
      checkVal("drain_res_valid", resValid, 1'b0);

      // Fresh reset so requester 0 leads the alternation
      rst = 1'b1;
      tick();
      rst = 1'b0;
      reqValid = 2'b11;
      resReady = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkVal($sformatf("alt_grant%0d", i), reqReady, (i % 2 == 0) ? 2'b01 : 2'b10);
         tick();
         checkVal($sformatf("alt_exec_ready%0d", i), reqReady, 2'b00);
         tick();
         checkVal($sformatf("alt_valid%0d", i), resValid, 1'b1);
         checkVal($sformatf("alt_id%0d", i), resId, (i % 2 == 0) ? 1'b0 : 1'b1);
         checkVal($sformatf("alt_data%0d", i), resData, (i % 2 == 0) ? 32'd12 : 32'd202);
      end

      // Backpressure in DONE: result from requester 1 must hold
      resReady = 1'b0;
      #1;
      checkVal("bp_ready_now", reqReady, 2'b00);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkVal($sformatf("bp_ready%0d", i), reqReady, 2'b00);
         checkVal($sformatf("bp_valid%0d", i), resValid, 1'b1);
         checkVal($sformatf("bp_id%0d", i), resId, 1'b1);
         checkVal($sformatf("bp_data%0d", i), resData, 32'd202);
         checkVal($sformatf("bp_rd%0d", i), resRd, 7'd30);
      end
      resReady = 1'b1;
      #1;
      checkVal("bp_release_grant", reqReady, 2'b01);
      tick();
      reqValid = 2'b00;
      #1;
      checkVal("bp_after_valid", resValid, 1'b0);
      tick();
      checkVal("bp_next_id", resId, 1'b0);
      checkVal("bp_next_data", resData, 32'd12);
      tick();

      // Requester 1 alone, then requester 0 joins
      reqValid = 2'b10;
      #1;
      checkVal("r1_first_grant", reqReady, 2'b10);
      tick();
      reqValid = 2'b11;
      #1;
      checkVal("r1_exec_ready", reqReady, 2'b00);
      tick();
      checkVal("r1_res_id", resId, 1'b1);
      checkVal("r1_res_data", resData, 32'd202);
      checkVal("r0_join_grant", reqReady, 2'b01);
      tick();
      reqValid = 2'b00;
      #1;
      checkVal("r0_join_exec", reqReady, 2'b00);
      tick();
      checkVal("r0_join_id", resId, 1'b0);
      checkVal("r0_join_data", resData, 32'd12);
      tick();

      // Async reset in EXEC (requester 1 in flight)
      reqValid = 2'b10;
      tick();
      checkVal("pre_rst_alu_rs", aluRs, 32'd200);
      rst = 1'b1;
      #1;
      checkVal("rst_exec_alu_rs", aluRs, 32'd0);
      checkVal("rst_exec_alu_op", aluOpcode, 5'd0);
      checkVal("rst_exec_res_data", resData, 32'd0);
      checkVal("rst_exec_ready", reqReady, 2'b00);
      tick();
      rst = 1'b0;
      reqValid = 2'b11;
      #1;
      checkVal("post_rst_exec_grant", reqReady, 2'b01);

      // Async reset in DONE
      tick();
      tick();
      checkVal("pre_rst_done_valid", resValid, 1'b1);
      rst = 1'b1;
      #1;
      checkVal("rst_done_valid", resValid, 1'b0);
      checkVal("rst_done_data", resData, 32'd0);
      checkVal("rst_done_alu_rt", aluRt, 32'd0);
      tick();
      rst = 1'b0;
      #1;
      checkVal("post_rst_done_grant", reqReady, 2'b01);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
      $finish;
   end

endmodule
